// File: rtl/rawspike_block_decoder_pkg.sv
// Shared constants, FSM state type and helpers for the rawspikes block decoder.
// Field positions within a rawspikes word live here so the decoder and its users agree.
package rawspike_block_decoder_pkg;

  localparam int NN_DEF        = 8;
  localparam int DEPTH_LOG_DEF = 3;
  localparam int TAG_W_DEF     = 8;

  localparam int RAW_W  = 18;
  localparam int ID_LSB = 8;
  localparam int SPK_A_MSB = 7;
  localparam int SPK_A_LSB = 4;
  localparam int SPK_B_MSB = 3;
  localparam int SPK_B_LSB = 0;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/rawspike_block_decoder_fifo.sv
// Show-ahead synchronous FIFO holding completed block results until the host pops them.
// A push into a full FIFO is accepted only if a pop happens on the same edge.
module rawspike_block_decoder_fifo #(
  parameter int DEPTH_LOG = 3,
  parameter int W         = 28
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [W-1:0]         data_i,
  input  logic                 pop_i,
  output logic [W-1:0]         data_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [DEPTH_LOG:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [W-1:0]         mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG:0]   count_q;
  logic                 do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (DEPTH_LOG+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + DEPTH_LOG'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + DEPTH_LOG'(1);
      if (do_push && !do_pop)      count_q <= count_q + (DEPTH_LOG+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (DEPTH_LOG+1)'(1);
    end
  end

endmodule

// File: rtl/rawspike_block_decoder.sv
// Rebuilds per-block pool A/B spike totals from the rawspikes stream, checks group-ID
// continuity and queues tagged block results for valid/ready readout.
module rawspike_block_decoder
  import rawspike_block_decoder_pkg::*;
#(
  parameter int NN        = NN_DEF,
  parameter int DEPTH_LOG = DEPTH_LOG_DEF,
  parameter int TAG_W     = TAG_W_DEF
) (
  input  logic               nClock,
  input  logic               neuronReset,
  input  logic [RAW_W-1:0]   raw_in,
  input  logic               raw_valid,
  input  logic               clear_err,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [NN+1:0]      cnt_a_out,
  output logic [NN+1:0]      cnt_b_out,
  output logic [TAG_W-1:0]   tag_out,
  output logic               seq_error,
  output logic               overflow,
  output logic [DEPTH_LOG:0] fifo_level,
  output state_e             dbg_state
);

  localparam int ID_W   = NN - 1;
  localparam int CNT_W  = NN + 2;
  localparam int ENTRY_W = 2 * CNT_W + TAG_W;

  // Handshake: an entry leaves the FIFO on any edge where out_valid && out_ready;
  // head fields are stable while out_valid is high and the consumer has not accepted.

  state_e              state_q;
  logic [CNT_W-1:0]    acc_a_q, acc_b_q;
  logic [ID_W-1:0]     exp_id_q;
  logic [TAG_W-1:0]    tag_q;
  logic                seq_error_q, overflow_q;

  logic [ID_W-1:0]     id;
  logic [2:0]          pa, pb;
  logic [CNT_W-1:0]    sum_a, sum_b;
  logic                id_match, id_zero, id_last;
  logic                blk_done, seq_err_set, ovf_set;
  logic                fifo_empty, fifo_full, pop;
  logic [ENTRY_W-1:0]  push_data, head_data;
  logic                unused_raw;

  assign id         = raw_in[ID_LSB +: ID_W];
  assign pa         = popcount4(raw_in[SPK_A_MSB:SPK_A_LSB]);
  assign pb         = popcount4(raw_in[SPK_B_MSB:SPK_B_LSB]);
  assign unused_raw = ^raw_in[RAW_W-1:ID_LSB+ID_W];

  always_comb begin
    id_match    = (id == exp_id_q);
    id_zero     = (id == '0);
    id_last     = (id == {ID_W{1'b1}});
    sum_a       = acc_a_q + CNT_W'(pa);
    sum_b       = acc_b_q + CNT_W'(pb);
    blk_done    = raw_valid && (state_q == ST_ACCUM) && id_match && id_last;
    seq_err_set = raw_valid && (state_q == ST_ACCUM) && !id_match;
    pop         = !fifo_empty && out_ready;
    ovf_set     = blk_done && fifo_full && !pop;
    push_data   = {sum_a, sum_b, tag_q};
  end

  always_ff @(posedge nClock or posedge neuronReset) begin
    if (neuronReset) begin
      state_q     <= ST_SYNC;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      exp_id_q    <= '0;
      tag_q       <= '0;
      seq_error_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (raw_valid) begin
        case (state_q)
          ST_SYNC: begin
            if (id_zero) begin
              acc_a_q  <= CNT_W'(pa);
              acc_b_q  <= CNT_W'(pb);
              exp_id_q <= ID_W'(1);
              state_q  <= ST_ACCUM;
            end
          end
          ST_ACCUM: begin
            if (id_match && id_last) begin
              // Block complete: result already pushed this edge; tag advances even if dropped.
              acc_a_q  <= '0;
              acc_b_q  <= '0;
              exp_id_q <= '0;
              tag_q    <= tag_q + TAG_W'(1);
            end else if (id_match) begin
              acc_a_q  <= sum_a;
              acc_b_q  <= sum_b;
              exp_id_q <= exp_id_q + ID_W'(1);
            end else if (id_zero) begin
              acc_a_q  <= CNT_W'(pa);
              acc_b_q  <= CNT_W'(pb);
              exp_id_q <= ID_W'(1);
            end else begin
              acc_a_q  <= '0;
              acc_b_q  <= '0;
              exp_id_q <= '0;
              state_q  <= ST_SYNC;
            end
          end
          default: state_q <= ST_SYNC;
        endcase
      end
      if (seq_err_set)    seq_error_q <= 1'b1;
      else if (clear_err) seq_error_q <= 1'b0;
      if (ovf_set)        overflow_q  <= 1'b1;
      else if (clear_err) overflow_q  <= 1'b0;
    end
  end

  rawspike_block_decoder_fifo #(
    .DEPTH_LOG (DEPTH_LOG),
    .W         (ENTRY_W)
  ) u_fifo (
    .clk_i   (nClock),
    .rst_i   (neuronReset),
    .push_i  (blk_done),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign cnt_a_out = head_data[ENTRY_W-1 -: CNT_W];
  assign cnt_b_out = head_data[TAG_W +: CNT_W];
  assign tag_out   = head_data[TAG_W-1:0];
  assign seq_error = seq_error_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rawspike_block_decoder.sv
// Bench for rawspike_block_decoder: directed scenarios plus random streams, all checked
// against a block-level reference model and an expected-entry queue.
module tb_rawspike_block_decoder;
  import rawspike_block_decoder_pkg::*;

  localparam int NGROUPS = 128;
  localparam int QCAP    = 8;

  logic        nClock = 1'b0;
  logic        neuronReset = 1'b0;
  logic [17:0] raw_in = '0;
  logic        raw_valid = 1'b0;
  logic        clear_err = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [9:0]  cnt_a_out, cnt_b_out;
  logic [7:0]  tag_out;
  logic        seq_error, overflow;
  logic [3:0]  fifo_level;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [27:0] exp_q[$];
  int          m_next;
  int          m_a, m_b;
  int          m_tag;
  logic        m_err, m_ovf;
  logic        rnd_mode = 1'b0;

  rawspike_block_decoder dut (
    .nClock      (nClock),
    .neuronReset (neuronReset),
    .raw_in      (raw_in),
    .raw_valid   (raw_valid),
    .clear_err   (clear_err),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .cnt_a_out   (cnt_a_out),
    .cnt_b_out   (cnt_b_out),
    .tag_out     (tag_out),
    .seq_error   (seq_error),
    .overflow    (overflow),
    .fifo_level  (fifo_level),
    .dbg_state   (dbg_state)
  );

  always #5 nClock = ~nClock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    check("seq_error", 32'(seq_error), 32'(m_err));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("state", 32'(dbg_state), 32'(m_next >= 0));
    if (exp_q.size() != 0)
      check("head", 32'({cnt_a_out, cnt_b_out, tag_out}), 32'(exp_q[0]));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_next = -1;
    m_a = 0; m_b = 0; m_tag = 0;
    m_err = 1'b0; m_ovf = 1'b0;
  endtask

  // m_next = next group expected in the current block, -1 when not synchronised
  task automatic model_step(input logic v, input logic [17:0] w, input logic rdy, input logic clr);
    int id, pa, pb;
    logic do_pop, do_push, set_err, set_ovf;
    logic [27:0] entry;
    do_pop = rdy && (exp_q.size() != 0);
    do_push = 1'b0; set_err = 1'b0; set_ovf = 1'b0;
    entry = '0;
    if (v) begin
      id = int'(w[14:8]);
      pa = $countones(w[7:4]);
      pb = $countones(w[3:0]);
      if (m_next < 0) begin
        if (id == 0) begin m_next = 1; m_a = pa; m_b = pb; end
      end else if (id == m_next) begin
        m_a += pa; m_b += pb; m_next++;
        if (m_next == NGROUPS) begin
          do_push = 1'b1;
          entry = {10'(m_a), 10'(m_b), 8'(m_tag)};
          m_tag = (m_tag + 1) % 256;
          m_next = 0; m_a = 0; m_b = 0;
        end
      end else begin
        set_err = 1'b1;
        if (id == 0) begin m_next = 1; m_a = pa; m_b = pb; end
        else begin m_next = -1; m_a = 0; m_b = 0; end
      end
    end
    if (do_push && exp_q.size() == QCAP && !do_pop) set_ovf = 1'b1;
    if (do_pop) void'(exp_q.pop_front());
    if (do_push && !set_ovf) exp_q.push_back(entry);
    if (set_err) m_err = 1'b1; else if (clr) m_err = 1'b0;
    if (set_ovf) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
  endtask

  // Called at a negedge: check what the previous edges produced, then drive the next cycle.
  task automatic cycle(input logic v, input logic [17:0] w, input logic rdy, input logic clr);
    check_outputs();
    raw_valid = v; raw_in = w; out_ready = rdy; clear_err = clr;
    model_step(v, w, rdy, clr);
    @(posedge nClock);
    @(negedge nClock);
  endtask

  task automatic do_reset();
    neuronReset = 1'b1;
    raw_valid = 1'b0; raw_in = '0; out_ready = 1'b0; clear_err = 1'b0;
    model_reset();
    @(posedge nClock);
    @(negedge nClock);
    check_outputs();
    check("rst_cnt_a", 32'(cnt_a_out), 0);
    check("rst_tag", 32'(tag_out), 0);
    neuronReset = 1'b0;
  endtask

  function automatic logic [17:0] mk_word(input int id, input logic [7:0] spk);
    logic [17:0] w;
    w = '0;
    w[14:8] = 7'(id);
    w[7:0] = spk;
    return w;
  endfunction

  // spk_rnd=0 sends 8'hF1 on every word; skip<0 means no gap
  task automatic send_block(input int first, input int last, input int skip, input logic spk_rnd,
                            input logic rdy, input logic last_rdy);
    logic [7:0] spk;
    logic r, c;
    for (int id = first; id <= last; id++) begin
      if (id == skip) continue;
      spk = spk_rnd ? 8'($urandom_range(0, 255)) : 8'hF1;
      r = rnd_mode ? 1'($urandom_range(0, 1)) : ((id == last) ? last_rdy : rdy);
      c = rnd_mode && ($urandom_range(0, 63) == 0);
      cycle(1'b1, mk_word(id, spk), r, c);
      r = rnd_mode ? 1'($urandom_range(0, 1)) : rdy;
      cycle(1'b0, '0, r, 1'b0);
      if (rnd_mode && $urandom_range(0, 3) == 0) cycle(1'b0, '0, 1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check("drain_level", 32'(fifo_level), 0);
  endtask

  initial begin
    // 1: one clean block of 8'hF1 words
    do_reset();
    send_block(0, 127, -1, 1'b0, 1'b0, 1'b0);
    check("t1_cnt_a", 32'(cnt_a_out), 512);
    check("t1_cnt_b", 32'(cnt_b_out), 128);
    check("t1_tag", 32'(tag_out), 0);
    check("t1_seq", 32'(seq_error), 0);
    drain();

    // 2: stream starts mid-block
    do_reset();
    send_block(37, 127, -1, 1'b1, 1'b0, 1'b0);
    check("t2_empty", 32'(out_valid), 0);
    send_block(0, 127, -1, 1'b1, 1'b0, 1'b0);
    check("t2_tag", 32'(tag_out), 0);
    drain();

    // 3: missing group mid-block, then clear
    do_reset();
    send_block(0, 127, 50, 1'b1, 1'b0, 1'b0);
    check("t3_seq", 32'(seq_error), 1);
    check("t3_level", 32'(fifo_level), 0);
    send_block(0, 127, -1, 1'b1, 1'b0, 1'b0);
    check("t3_tag", 32'(tag_out), 0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t3_cleared", 32'(seq_error), 0);
    drain();

    // 4: overflow with nine blocks and no consumer
    do_reset();
    for (int b = 0; b < 9; b++) send_block(0, 127, -1, 1'b1, 1'b0, 1'b0);
    check("t4_level", 32'(fifo_level), 8);
    check("t4_ovf", 32'(overflow), 1);
    drain();
    send_block(0, 127, -1, 1'b1, 1'b0, 1'b0);
    check("t4_next_tag", 32'(tag_out), 9);
    drain();

    // 5: full FIFO with push and pop on the same edge
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t5_ovf_clr", 32'(overflow), 0);
    do_reset();
    for (int b = 0; b < 8; b++) send_block(0, 127, -1, 1'b1, 1'b0, 1'b0);
    send_block(0, 127, -1, 1'b1, 1'b0, 1'b1);
    check("t5_level", 32'(fifo_level), 8);
    check("t5_ovf", 32'(overflow), 0);
    check("t5_head_tag", 32'(tag_out), 1);
    drain();

    // 6: reset mid-block, then a clean block
    do_reset();
    send_block(0, 60, -1, 1'b1, 1'b0, 1'b0);
    check("t6_pre_state", 32'(dbg_state), 32'(ST_ACCUM));
    do_reset();
    check("t6_state", 32'(dbg_state), 32'(ST_SYNC));
    check("t6_level", 32'(fifo_level), 0);
    send_block(0, 127, -1, 1'b1, 1'b0, 1'b0);
    check("t6_tag", 32'(tag_out), 0);
    drain();

    // random streams: gaps, random ready, occasional clears
    do_reset();
    rnd_mode = 1'b1;
    for (int b = 0; b < 14; b++) begin
      if ($urandom_range(0, 3) == 0)
        send_block(0, 127, $urandom_range(1, 126), 1'b1, 1'b0, 1'b0);
      else if ($urandom_range(0, 5) == 0)
        send_block($urandom_range(1, 120), 127, -1, 1'b1, 1'b0, 1'b0);
      else
        send_block(0, 127, -1, 1'b1, 1'b0, 1'b0);
    end
    rnd_mode = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
